det_trial_sequencer: RTL and testbench

- Hardware replacement for the software statistical bench around the serial sequence detectors (e.g. detectorKN59).
- Runs a programmable number of fixed-length trials. Each trial resets the detector for one cycle, then streams TRIAL_LEN bits into it.
- A trial counts as a hit if the detector output is high in any cycle of the detection window. At most one hit is counted per trial.
- Reports trial and hit counters so firmware computes P = hit_count / trial_count.

---
 rtl/det_stat_pkg.sv | 20 ++
 rtl/lfsr16_src.sv | 27 ++
 rtl/det_trial_sequencer.sv | 125 ++++++++++++
 tb/tb_det_trial_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/det_stat_pkg.sv
// Shared types and constants for the detector trial sequencer.
// The helper sizes the per-trial data-cycle index, which counts 1..TRIAL_LEN.
package det_stat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRST,
    RUN,
    DONE
  } state_t;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shift form: bits 0, 2, 3, 5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic int idx_width(input int len);
    return (len < 2) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/lfsr16_src.sv
// 16-bit right-shifting Fibonacci LFSR used as the internal bit source.
// The feedback bit enters at bit 15, and bit_out is bit 0.
module lfsr16_src
  import det_stat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] seed,
  output logic        bit_out
);

  logic [15:0] lfsr;

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || load) begin
      lfsr <= seed;
    end else if (shift) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  assign bit_out = lfsr[0];

endmodule

// File: rtl/det_trial_sequencer.sv
// Runs back-to-back fixed-length trials against a serial sequence detector.
// It counts the completed trials and the trials in which det fired inside the window.
module det_trial_sequencer
  import det_stat_pkg::*;
#(
  parameter int          TRIAL_LEN = 9,
  parameter int          WIN_START = 5,
  parameter int          WIN_END   = 9,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_trials,
  input  logic             src_sel,
  input  logic             ext_data,
  input  logic             det,
  output logic             det_reset,
  output logic             det_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] trial_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam int K_W = idx_width(TRIAL_LEN);

  if (WIN_START < 1) begin : g_bad_win_start
    $error("det_trial_sequencer: WIN_START must be at least 1");
  end
  if (WIN_END > TRIAL_LEN) begin : g_bad_win_end
    $error("det_trial_sequencer: WIN_END must not exceed TRIAL_LEN");
  end
  if (WIN_START > WIN_END) begin : g_bad_win_order
    $error("det_trial_sequencer: WIN_START must not exceed WIN_END");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("det_trial_sequencer: LFSR_SEED must be nonzero");
  end

  state_t           state, state_next;
  logic [K_W-1:0]   k;
  logic             hit_flag;
  logic [CNT_W-1:0] n_lat;
  logic             sel_lat;
  logic             lfsr_bit;
  logic             in_window, hit_now, last_cycle, trial_end;
  logic [CNT_W-1:0] trial_inc;

  assign in_window  = (k >= K_W'(WIN_START)) && (k <= K_W'(WIN_END));
  assign hit_now    = (state == RUN) && det && in_window;
  assign last_cycle = (state == RUN) && (k == K_W'(TRIAL_LEN));
  // abort discards the increment that would otherwise close the trial.
  assign trial_end  = last_cycle && !abort;
  assign trial_inc  = trial_count + CNT_W'(1);

  lfsr16_src u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    ((state == IDLE) && start),
    .shift   (state == RUN),
    .seed    (LFSR_SEED),
    .bit_out (lfsr_bit)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_trials == '0) ? DONE : DRST;
      DRST:    state_next = RUN;
      RUN:     if (last_cycle) state_next = (trial_inc == n_lat) ? DONE : DRST;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      trial_count <= '0;
      hit_count   <= '0;
      hit_flag    <= 1'b0;
      k           <= K_W'(1);
      n_lat       <= '0;
      sel_lat     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_lat       <= num_trials;
          sel_lat     <= src_sel;
          trial_count <= '0;
          hit_count   <= '0;
        end
        DRST: begin
          hit_flag <= 1'b0;
          k        <= K_W'(1);
        end
        RUN: begin
          k <= k + K_W'(1);
          if (hit_now) hit_flag <= 1'b1;
          if (trial_end) begin
            trial_count <= trial_inc;
            // A hit in the final window cycle still counts for this trial.
            if (hit_flag || hit_now) hit_count <= hit_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == DRST) || (state == RUN);
  assign det_reset = (state == RUN);
  assign done      = (state == DONE);
  assign det_data  = (state == RUN) && (sel_lat ? ext_data : lfsr_bit);

endmodule

// File: tb/tb_det_trial_sequencer.sv
// Self-checking bench: directed trial scenarios with literal expectations, then randomized traffic.
// A trial-level model is checked against the outputs on every cycle.
module tb_det_trial_sequencer;

  localparam int          L    = 9;
  localparam int          WS   = 5;
  localparam int          WE   = 9;
  localparam int          W    = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic         src_sel = 1'b0, ext_data = 1'b0, det = 1'b0;
  logic [W-1:0] num_trials = '0;
  logic         det_reset, det_data, busy, done;
  logic [W-1:0] trial_count, hit_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  det_trial_sequencer #(
    .TRIAL_LEN (L), .WIN_START (WS), .WIN_END (WE), .CNT_W (W), .LFSR_SEED (SEED)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .num_trials (num_trials), .src_sel (src_sel), .ext_data (ext_data), .det (det),
    .det_reset (det_reset), .det_data (det_data), .busy (busy), .done (done),
    .trial_count (trial_count), .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a run is a sequence of (L+1)-cycle trials; position 0 is the detector reset cycle.
  bit          m_active = 1'b0, m_done = 1'b0, m_sel = 1'b0, m_hit = 1'b0;
  int          m_cyc = 0, m_trials = 0, m_hits = 0, m_n = 0;
  logic [15:0] m_lfsr = SEED;

  always @(posedge clk) begin : model
    int pos;
    if (!reset) begin
      m_active = 1'b0; m_done = 1'b0; m_sel = 1'b0; m_hit = 1'b0;
      m_trials = 0; m_hits = 0; m_cyc = 0; m_lfsr = SEED;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_n = int'(num_trials); m_sel = src_sel; m_lfsr = SEED;
        m_trials = 0; m_hits = 0; m_cyc = 0;
        if (m_n == 0) m_done = 1'b1;
        else          m_active = 1'b1;
      end
    end else if (abort) begin
      m_active = 1'b0;
    end else begin
      pos = m_cyc % (L + 1);
      if (pos == 0) begin
        m_hit = 1'b0;
      end else begin
        if (det && pos >= WS && pos <= WE) m_hit = 1'b1;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        if (pos == L) begin
          m_trials++;
          if (m_hit) m_hits++;
          if (m_trials == m_n) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    int pos;
    bit run_cyc;
    if (cmp_en) begin
      pos     = m_cyc % (L + 1);
      run_cyc = m_active && (pos != 0);
      check("busy", busy, m_active);
      check("det_reset", det_reset, run_cyc);
      check("det_data", det_data, run_cyc ? (m_sel ? ext_data : m_lfsr[0]) : 1'b0);
      check("done", done, m_done);
      check("trial_count", trial_count, m_trials);
      check("hit_count", hit_count, m_hits);
    end
  end

  // Observations gathered by the directed runner (cycle 1 = first cycle after the start edge).
  int           r_done, r_busy, r_drhigh;
  int           r_drst_low[$];
  logic [3:0]   r_bits;
  logic [W-1:0] r_tc1;

  task automatic run_directed(input int n, input bit sel, input logic [15:0] kmask,
                              input logic [7:0] tmask, input int ab_t, input int ab_k);
    int ncyc;
    ncyc = n * (L + 1) + 4;
    r_done = -1; r_busy = 0; r_drhigh = 0; r_drst_low.delete(); r_bits = '0; r_tc1 = '1;
    start = 1'b1; num_trials = W'(n); src_sel = sel; abort = 1'b0; det = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      int pos, t;
      pos      = (c - 1) % (L + 1);
      t        = (c - 1) / (L + 1);
      det      = (pos != 0) && (t < 8) ? (tmask[t] && kmask[pos]) : 1'b0;
      abort    = (t == ab_t) && (pos == ab_k);
      ext_data = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy) r_busy++;
      if (done && r_done < 0) r_done = c;
      if (busy && !det_reset) r_drst_low.push_back(c);
      if (det_reset) r_drhigh++;
      if (c == 1) r_tc1 = trial_count;
      if (c >= 2 && c <= 5) r_bits[c-2] = det_data;
      @(posedge clk); #1;
    end
    det = 1'b0; abort = 1'b0;
  endtask

  function automatic int drst_at(input int i);
    return (i < r_drst_low.size()) ? r_drst_low[i] : -1;
  endfunction

  initial begin
    cmp_en = 1'b1;
    reset  = 1'b0;
    @(posedge clk); #1;
    check("reset_trial_count", trial_count, 0);
    check("reset_busy", busy, 0);
    check("reset_det_reset", det_reset, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single trial, det only at k=5.
    run_directed(1, 1'b1, 16'h0020, 8'h01, -1, -1);
    check("s1_done_cycle", r_done, 11);
    check("s1_busy_cycles", r_busy, 10);
    check("s1_drst_count", r_drst_low.size(), 1);
    check("s1_tc", trial_count, 1);
    check("s1_hc", hit_count, 1);
    check("s1_model_hits", m_hits, 1);

    // det just outside the window, then at its last cycle, then across the whole window.
    run_directed(1, 1'b1, 16'h0010, 8'h01, -1, -1);
    check("s2_hc_k4", hit_count, 0);
    check("s2_model_hits", m_hits, 0);
    run_directed(1, 1'b1, 16'h0200, 8'h01, -1, -1);
    check("s3_hc_k9", hit_count, 1);
    run_directed(1, 1'b1, 16'h03E0, 8'h01, -1, -1);
    check("s4_hc_k5to9", hit_count, 1);

    // Three trials, det at k=6 in trials 1 and 3.
    run_directed(3, 1'b1, 16'h0040, 8'h05, -1, -1);
    check("s5_tc", trial_count, 3);
    check("s5_hc", hit_count, 2);
    check("s5_busy_cycles", r_busy, 30);
    check("s5_done_cycle", r_done, 31);
    check("s5_drst_count", r_drst_low.size(), 3);
    check("s5_drst0", drst_at(0), 1);
    check("s5_drst1", drst_at(1), 11);
    check("s5_drst2", drst_at(2), 21);

    // Abort in trial 2 at k=3.
    run_directed(5, 1'b1, 16'h0000, 8'h00, 1, 3);
    check("s6_tc", trial_count, 1);
    check("s6_no_done", r_done, -1);
    check("s6_busy_cycles", r_busy, 14);

    // Internal LFSR source; the new start clears the counters left by the abort.
    run_directed(1, 1'b0, 16'h0000, 8'h00, -1, -1);
    check("s7_tc_cleared", r_tc1, 0);
    check("s7_lfsr_bits", r_bits, 4'b0001);
    check("s7_tc", trial_count, 1);

    // Zero trials.
    run_directed(0, 1'b0, 16'h0000, 8'h00, -1, -1);
    check("s8_done_cycle", r_done, 1);
    check("s8_busy_cycles", r_busy, 0);
    check("s8_det_reset_high", r_drhigh, 0);
    check("s8_tc", trial_count, 0);
    check("s8_hc", hit_count, 0);

    // Randomized traffic: starts while busy, aborts, and occasional mid-run resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset      = ($urandom_range(0, 299) != 0);
      start      = ($urandom_range(0, 5) == 0);
      num_trials = W'($urandom_range(0, 4));
      src_sel    = 1'($urandom_range(0, 1));
      ext_data   = 1'($urandom_range(0, 1));
      det        = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; det = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
